// File: rtl/uart_8n1_pkg.sv
// ============================================================================
// Module   : uart_8n1_pkg
// Brief    : Shared framing constants and FSM state encoding for the 8N1 UART.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_8n1_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO of 2**ADDR_W entries with wrap-around pointers and count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int ADDR_W = 2,
  parameter int WIDTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WIDTH-1:0]  i_data,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == (ADDR_W + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_8n1_transmitter.sv
// ============================================================================
// Module   : uart_8n1_transmitter
// Brief    : 8N1 UART transmitter on a 16x baud clock. Define UART_TX_FIFO_EN
//            for a 2**FIFO_ADDR_W byte FIFO instead of a single holding register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_8n1_transmitter
  import uart_8n1_pkg::*;
#(
  parameter int FIFO_ADDR_W = 2
) (
  input  logic                 clk_baud_16x,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] xmit_data,
  input  logic                 xmit_write,
  output logic                 xmit_busy,
  output logic                 xmit_idle,
  output logic                 xmit_error,
  output logic                 tx
);

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_last_tick;
  logic [FIFO_ADDR_W:0] w_count;
  logic [DATA_BITS-1:0] w_head;

  tx_state_t            r_state;
  logic [TICK_W-1:0]    r_tick;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_error;

  // A write is refused whenever the buffer was full at the start of the
  // cycle, even if the FSM frees a slot at the same edge.
  assign w_push      = xmit_write && !w_full;
  assign w_last_tick = (r_tick == LAST_TICK);
  assign w_pop       = !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_last_tick));

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(
    .ADDR_W (FIFO_ADDR_W),
    .WIDTH  (DATA_BITS)
  ) u_fifo (
    .i_clk   (clk_baud_16x),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (xmit_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
`else
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_valid;

  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      r_hold  <= '0;
      r_valid <= 1'b0;
    end else if (w_push) begin
      r_hold  <= xmit_data;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign w_head  = r_hold;
  assign w_full  = r_valid;
  assign w_empty = !r_valid;
  assign w_count = {{FIFO_ADDR_W{1'b0}}, r_valid};
`endif

  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_tick  <= '0;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_tick <= r_tick + 1'b1;
          if (w_last_tick) begin
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          r_tick <= r_tick + 1'b1;
          if (w_last_tick) begin
            if (r_bit == LAST_BIT) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 1'b1;
            end
          end
        end
        ST_STOP: begin
          r_tick <= r_tick + 1'b1;
          // Chaining straight into the next start bit keeps frames gap-free.
          if (w_last_tick) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      r_error <= 1'b0;
    end else begin
      r_error <= xmit_write && w_full;
    end
  end

  assign tx         = r_tx;
  assign xmit_busy  = w_full;
  assign xmit_error = r_error;
  assign xmit_idle  = (r_state == ST_IDLE) && (w_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_uart_8n1_transmitter.sv
// ============================================================================
// Module   : tb_uart_8n1_transmitter
// Brief    : Directed, table-driven bench for uart_8n1_transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_8n1_transmitter;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b0;
  logic [7:0] xmit_data  = 8'h00;
  logic       xmit_write = 1'b0;
  logic       xmit_busy;
  logic       xmit_idle;
  logic       xmit_error;
  logic       tx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // frame[i] is the i-th bit on the wire (start first)
  } vec_t;

  vec_t vecs [6];

  logic       sched_en  [160];
  logic [7:0] sched_dat [160];
  int         err_at;
  int         busy_at;
  logic       busy_exp;

`ifdef UART_TX_FIFO_EN
  localparam logic BUSY_ONE = 1'b0;
`else
  localparam logic BUSY_ONE = 1'b1;
`endif

  uart_8n1_transmitter #(.FIFO_ADDR_W(2)) dut (
    .clk_baud_16x (clk),
    .reset_n      (reset_n),
    .xmit_data    (xmit_data),
    .xmit_write   (xmit_write),
    .xmit_busy    (xmit_busy),
    .xmit_idle    (xmit_idle),
    .xmit_error   (xmit_error),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 160; i++) begin
      sched_en[i]  = 1'b0;
      sched_dat[i] = 8'h00;
    end
    err_at   = -1;
    busy_at  = -1;
    busy_exp = 1'b0;
  endtask

  // Accept a byte from an idle line; returns at the first start-bit sample.
  task automatic start_write(input logic [7:0] d);
    xmit_write = 1'b1;
    xmit_data  = d;
    step();
    xmit_write = 1'b0;
    check("idle_drop", {31'd0, xmit_idle}, 32'd0);
    check("busy_after_write", {31'd0, xmit_busy}, {31'd0, BUSY_ONE});
    step();
  endtask

  // Checks 160 consecutive clocks of tx against f, applying scheduled writes.
  task automatic check_frame(input logic [9:0] f, input string nm);
    logic bit_ok;
    logic err_ok;
    bit_ok = 1'b1;
    err_ok = 1'b1;
    for (int i = 0; i < 160; i++) begin
      if (i % 16 == 0) bit_ok = 1'b1;
      if (tx !== f[i/16]) bit_ok = 1'b0;
      if (xmit_error !== (i == err_at)) err_ok = 1'b0;
      if (i == busy_at) check({nm, "_busy"}, {31'd0, xmit_busy}, {31'd0, busy_exp});
      xmit_write = sched_en[i];
      xmit_data  = sched_dat[i];
      step();
      if (i % 16 == 15) check($sformatf("%s_bit%0d", nm, i / 16), {31'd0, bit_ok}, 32'd1);
    end
    xmit_write = 1'b0;
    check({nm, "_err"}, {31'd0, err_ok}, 32'd1);
  endtask

  task automatic check_quiet(input string nm, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1 || xmit_idle !== 1'b1 || xmit_busy !== 1'b0) ok = 1'b0;
      step();
    end
    check(nm, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{8'h56, 10'b1010101100};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};
    vecs[4] = '{8'h01, 10'b1000000010};
    vecs[5] = '{8'h80, 10'b1100000000};
    clear_sched();

    // Reset state
    repeat (3) step();
    check("rst_tx_held", {31'd0, tx}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, xmit_busy}, 32'd0);
    check("rst_idle", {31'd0, xmit_idle}, 32'd1);
    check("rst_error", {31'd0, xmit_error}, 32'd0);

    // Single frames from the table
    foreach (vecs[k]) begin
      clear_sched();
      start_write(vecs[k].data);
      check_frame(vecs[k].frame, $sformatf("frame_%02h", vecs[k].data));
      check($sformatf("idle_after_%02h", vecs[k].data), {31'd0, xmit_idle}, 32'd1);
      check_quiet($sformatf("quiet_after_%02h", vecs[k].data), 3);
    end

    // Back-to-back frames with no high gap
    clear_sched();
    start_write(8'hAB);
    sched_en[0]  = 1'b1;
    sched_dat[0] = 8'hFE;
    check_frame(10'b1101010110, "b2b_ab");
    clear_sched();
    check_frame(10'b1111111100, "b2b_fe");
    check("b2b_idle", {31'd0, xmit_idle}, 32'd1);
    check_quiet("b2b_quiet", 32);

`ifndef UART_TX_FIFO_EN
    // Write landing on the pop edge is still refused
    clear_sched();
    xmit_write = 1'b1;
    xmit_data  = 8'h11;
    step();
    xmit_data  = 8'h77;
    step();
    xmit_write = 1'b0;
    check("err_at_pop", {31'd0, xmit_error}, 32'd1);
    check("busy_at_pop", {31'd0, xmit_busy}, 32'd0);
    err_at = 0;
    check_frame(10'b1000100010, "pop_11");
    clear_sched();
    check("pop_idle", {31'd0, xmit_idle}, 32'd1);
    check_quiet("pop_no77", 40);

    // Full holding register, then a dropped write mid-frame
    clear_sched();
    start_write(8'h22);
    sched_en[0]   = 1'b1;
    sched_dat[0]  = 8'h44;
    sched_en[40]  = 1'b1;
    sched_dat[40] = 8'h77;
    err_at   = 41;
    busy_at  = 30;
    busy_exp = 1'b1;
    check_frame(10'b1001000100, "full_22");
    clear_sched();
    check_frame(10'b1010001000, "full_44");
    check("full_idle", {31'd0, xmit_idle}, 32'd1);
    check_quiet("full_no77", 48);
`else
    // FIFO fills during a frame, drains in order, busy clears at first pop
    clear_sched();
    start_write(8'h10);
    for (int i = 0; i < 4; i++) begin
      sched_en[i]  = 1'b1;
      sched_dat[i] = 8'h31 + 8'(i);
    end
    sched_en[20]  = 1'b1;
    sched_dat[20] = 8'h77;
    err_at   = 21;
    busy_at  = 4;
    busy_exp = 1'b1;
    check_frame(10'b1000100000, "fifo_10");
    clear_sched();
    busy_at  = 0;
    busy_exp = 1'b0;
    check_frame(10'b1001100010, "fifo_31");
    clear_sched();
    check_frame(10'b1001100100, "fifo_32");
    check_frame(10'b1001100110, "fifo_33");
    check_frame(10'b1001101000, "fifo_34");
    check("fifo_idle", {31'd0, xmit_idle}, 32'd1);
    check_quiet("fifo_no77", 48);
`endif

    // Reset in the middle of a frame discards frame and buffered byte
    clear_sched();
    start_write(8'hCA);
    xmit_write = 1'b1;
    xmit_data  = 8'h3C;
    step();
    xmit_write = 1'b0;
    repeat (60) step();
    check("pre_rst_tx", {31'd0, tx}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_idle", {31'd0, xmit_idle}, 32'd1);
    check("mid_rst_busy", {31'd0, xmit_busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_quiet("after_rst_quiet", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
